// File: rtl/mp_add_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a word counter.
  // A single-word counter still needs one bit, so the result never drops below 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/response bundle between a requester and mp_add_seq.
interface mp_add_seq_if
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
);
  localparam int N = WORDS * WORD_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  // Requester side.
  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Sequencer side.
  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/mp_add_seq_rca16.sv
// Existing 16-bit ripple-carry adder, one full adder per bit.
module rca16
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout
);

  logic [WORD_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WORD_W];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: WORDS x 16-bit operands pushed through one
// shared rca16, LSB word first, with the carry chained through a register.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  mp_add_seq_if.slave  bus
);

  localparam int                N     = WORDS * WORD_W;
  localparam int                IDX_W = clog2(WORDS);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WORDS - 1);

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic                           carry_q;
  logic [WORDS-1:0][WORD_W-1:0]   op_a;
  logic [WORDS-1:0][WORD_W-1:0]   op_b;
  logic [WORDS-1:0][WORD_W-1:0]   sum_q;
  logic                           cout_q;
  logic                           ovf_q;

  word_t rca_s;
  logic  rca_co;

  logic accept;
  logic running;
  logic last;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign running = (state == RUN);
  assign last    = (idx == LAST);

  // Single shared datapath; the word mux is just the idx select.
  rca16 u_rca (
    .a    (op_a[idx]),
    .b    (op_b[idx]),
    .cin  (carry_q),
    .s    (rca_s),
    .cout (rca_co)
  );

  // Control: state, word index and inter-word carry.
  // idx holds at the last word rather than wrapping; it restarts on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state   <= RUN;
            idx     <= '0;
            carry_q <= bus.op_sub;
          end
        end
        RUN: begin
          carry_q <= rca_co;
          if (last) state <= DONE;
          else      idx   <= idx + 1'b1;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture; subtract is A + ~B + 1, the +1 coming from carry_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (accept) begin
      op_a <= bus.a;
      op_b <= bus.op_sub ? ~bus.b : bus.b;
    end
  end

  // Result words land one per RUN cycle, so sum is only coherent in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (running) begin
      sum_q[idx] <= rca_s;
    end
  end

  // Final flags come from the top word only; ovf uses the (possibly inverted) B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (running && last) begin
      cout_q <= rca_co;
      ovf_q  <= (op_a[WORDS-1][WORD_W-1] == op_b[WORDS-1][WORD_W-1]) &&
                (rca_s[WORD_W-1] != op_a[WORDS-1][WORD_W-1]);
    end
  end

  // Handshake outputs decode straight off the state register.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = N'(sum_q);
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed-vector bench for mp_add_seq with WORDS=4 (64-bit operands).
module tb_mp_add_seq;
  import mp_add_pkg::*;

  localparam int WORDS = 4;
  localparam int N     = WORDS * WORD_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mp_add_seq_if #(.WORDS(WORDS)) bus ();

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; return just after the accepting edge.
  task automatic issue(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, N'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input logic [N-1:0] es, input logic ec, input logic eo);
    int c;
    bus.out_ready = 1'b1;
    issue(tag, a, b, sub);
    wait_out(c);
    chk({tag, "_lat"}, N'(c), 64'd4);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, N'(bus.cout), N'(ec));
    chk({tag, "_ovf"}, N'(bus.ovf), N'(eo));
    @(posedge clk);
    #1;
    chk({tag, "_ov_drop"}, N'(bus.out_valid), 64'd0);
    chk({tag, "_ir_back"}, N'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int c;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", N'(bus.in_ready), 64'd1);
    chk("rst_out_valid", N'(bus.out_valid), 64'd0);
    chk("rst_sum", bus.sum, 64'd0);
    chk("rst_cout", N'(bus.cout), 64'd0);
    chk("rst_ovf", N'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("sub_borrow", 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Backpressure: result held while out_ready is low, new requests ignored
    bus.out_ready = 1'b0;
    issue("bp", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    wait_out(c);
    chk("bp_lat", N'(c), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 64'hFFFF_0000_FFFF_0000;
      bus.b        = 64'h0F0F_0F0F_0F0F_0F0F;
      bus.op_sub   = 1'b1;
      chk("bp_sum", bus.sum, 64'h2345_6789_ABCD_F001);
      chk("bp_out_valid", N'(bus.out_valid), 64'd1);
      chk("bp_in_ready", N'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_sum_final", bus.sum, 64'h2345_6789_ABCD_F001);
    chk("bp_cout", N'(bus.cout), 64'd0);
    chk("bp_ovf", N'(bus.ovf), 64'd0);
    @(posedge clk);
    #1;
    chk("bp_ov_drop", N'(bus.out_valid), 64'd0);
    chk("bp_ir_back", N'(bus.in_ready), 64'd1);

    // Asynchronous reset during the second RUN cycle
    issue("mid", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_w0_written", N'(bus.sum[15:0]), 64'hF001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", N'(bus.out_valid), 64'd0);
    chk("mid_in_ready", N'(bus.in_ready), 64'd1);
    chk("mid_sum", bus.sum, 64'd0);
    chk("mid_cout", N'(bus.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_sub", 64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
